// File: rtl/barrel_thread_scheduler_if.sv
// Issue, writeback and start/halt bundle for the barrel thread scheduler.
// Counter select/value signals exist only when BARREL_SCHED_PERF_EN is defined.
interface barrel_thread_scheduler_if #(
    parameter int NUM_THREADS = 16,
    parameter int PC_WIDTH    = 12
);
    localparam int TW = $clog2(NUM_THREADS);

    logic                   start_i;
    logic [NUM_THREADS-1:0] start_mask_i;
    logic                   halt_i;
    logic [NUM_THREADS-1:0] halt_mask_i;
    logic                   wb_valid_i;
    logic [TW-1:0]          wb_tid_i;
    logic [PC_WIDTH-1:0]    wb_pc_i;
    logic                   issue_valid_o;
    logic [TW-1:0]          issue_tid_o;
    logic [PC_WIDTH-1:0]    issue_pc_o;
    logic [NUM_THREADS-1:0] running_o;
    logic                   drained_o;
`ifdef BARREL_SCHED_PERF_EN
    logic [TW-1:0]          cnt_sel_i;
    logic [31:0]            cnt_value_o;

    modport master (
        output start_i, start_mask_i, halt_i, halt_mask_i,
        output wb_valid_i, wb_tid_i, wb_pc_i, cnt_sel_i,
        input  issue_valid_o, issue_tid_o, issue_pc_o,
        input  running_o, drained_o, cnt_value_o
    );
    modport slave (
        input  start_i, start_mask_i, halt_i, halt_mask_i,
        input  wb_valid_i, wb_tid_i, wb_pc_i, cnt_sel_i,
        output issue_valid_o, issue_tid_o, issue_pc_o,
        output running_o, drained_o, cnt_value_o
    );
`else
    modport master (
        output start_i, start_mask_i, halt_i, halt_mask_i,
        output wb_valid_i, wb_tid_i, wb_pc_i,
        input  issue_valid_o, issue_tid_o, issue_pc_o,
        input  running_o, drained_o
    );
    modport slave (
        input  start_i, start_mask_i, halt_i, halt_mask_i,
        input  wb_valid_i, wb_tid_i, wb_pc_i,
        output issue_valid_o, issue_tid_o, issue_pc_o,
        output running_o, drained_o
    );
`endif
endinterface

// File: rtl/barrel_thread_scheduler.sv
// Round-robin barrel thread issue scheduler with start/halt and drain FSM.
// Optional per-thread issue counters when BARREL_SCHED_PERF_EN is defined.
module barrel_thread_scheduler #(
    parameter int                  NUM_THREADS     = 16,
    parameter int                  NUM_PIPE_STAGES = 16,
    parameter int                  PC_WIDTH        = 12,
    parameter logic [PC_WIDTH-1:0] STARTUP_ADDR    = '0
) (
    input logic                      clk,
    input logic                      reset_n,
    barrel_thread_scheduler_if.slave bus
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int DW = $clog2(NUM_PIPE_STAGES + 1);

    if (NUM_THREADS < NUM_PIPE_STAGES) begin : g_bad_cfg
        $error("NUM_THREADS must be >= NUM_PIPE_STAGES");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic [TW-1:0]          slot_q;
    logic [NUM_THREADS-1:0] run_q, run_d;
    logic [NUM_THREADS-1:0] start_eff, halt_eff, load_mask;
    logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
    logic                   wb_hit, bypass;

    // Halt beats start for any thread named in both masks.
    always_comb begin
        halt_eff  = bus.halt_i ? bus.halt_mask_i : '0;
        start_eff = bus.start_i ? (bus.start_mask_i & ~halt_eff) : '0;
        load_mask = start_eff & ~run_q;
        run_d     = (run_q | start_eff) & ~halt_eff;
        wb_hit    = bus.wb_valid_i
                 && (32'(bus.wb_tid_i) < NUM_THREADS)
                 && run_q[bus.wb_tid_i];
        bypass    = wb_hit && (bus.wb_tid_i == slot_q);
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (|start_eff) state_d = RUN;
            end
            RUN: begin
                if (run_d == '0) begin
                    state_d = DRAIN;
                    drain_d = DW'(NUM_PIPE_STAGES);
                end
            end
            DRAIN: begin
                if (|start_eff) begin
                    state_d = RUN;
                    drain_d = '0;
                end else if (drain_q <= DW'(1)) begin
                    state_d = IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            drain_q           <= '0;
            slot_q            <= '0;
            run_q             <= '0;
            bus.issue_valid_o <= 1'b0;
            bus.issue_tid_o   <= '0;
            bus.issue_pc_o    <= STARTUP_ADDR;
            for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= STARTUP_ADDR;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            run_q   <= run_d;
            slot_q  <= (slot_q == TW'(NUM_THREADS - 1)) ? '0 : slot_q + TW'(1);
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (load_mask[i])
                    pc_q[i] <= STARTUP_ADDR;
                else if (wb_hit && (bus.wb_tid_i == TW'(i)))
                    pc_q[i] <= bus.wb_pc_i;
            end
            bus.issue_valid_o <= run_q[slot_q] && (state_q != IDLE);
            bus.issue_tid_o   <= slot_q;
            bus.issue_pc_o    <= bypass ? bus.wb_pc_i : pc_q[slot_q];
        end
    end

    assign bus.running_o = run_q;
    assign bus.drained_o = (state_q == IDLE);

`ifdef BARREL_SCHED_PERF_EN
    logic [31:0] cnt_q [NUM_THREADS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.cnt_value_o <= '0;
            for (int i = 0; i < NUM_THREADS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (load_mask[i])
                    cnt_q[i] <= '0;
                else if (bus.issue_valid_o && (bus.issue_tid_o == TW'(i)))
                    cnt_q[i] <= cnt_q[i] + 32'd1;
            end
            bus.cnt_value_o <= (32'(bus.cnt_sel_i) < NUM_THREADS)
                             ? cnt_q[bus.cnt_sel_i] : '0;
        end
    end
`endif
endmodule

// File: tb/tb_barrel_thread_scheduler.sv
// Directed bench for barrel_thread_scheduler: a 16/16 and a 6/4 instance.
// Per-thread counters are exercised when BARREL_SCHED_PERF_EN is defined.
module tb_barrel_thread_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    barrel_thread_scheduler_if #(.NUM_THREADS(16), .PC_WIDTH(12)) if16 ();
    barrel_thread_scheduler_if #(.NUM_THREADS(6),  .PC_WIDTH(12)) if6 ();

    barrel_thread_scheduler #(
        .NUM_THREADS(16), .NUM_PIPE_STAGES(16),
        .PC_WIDTH(12), .STARTUP_ADDR(12'h000)
    ) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16.slave));

    barrel_thread_scheduler #(
        .NUM_THREADS(6), .NUM_PIPE_STAGES(4),
        .PC_WIDTH(12), .STARTUP_ADDR(12'h040)
    ) dut6 (.clk(clk), .reset_n(reset_n), .bus(if6.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if16.start_i = 0; if16.start_mask_i = '0;
        if16.halt_i = 0;  if16.halt_mask_i = '0;
        if16.wb_valid_i = 0; if16.wb_tid_i = '0; if16.wb_pc_i = '0;
        if6.start_i = 0; if6.start_mask_i = '0;
        if6.halt_i = 0;  if6.halt_mask_i = '0;
        if6.wb_valid_i = 0; if6.wb_tid_i = '0; if6.wb_pc_i = '0;
`ifdef BARREL_SCHED_PERF_EN
        if16.cnt_sel_i = '0;
        if6.cnt_sel_i = '0;
`endif
        reset_n = 0;
        repeat (2) tick();
        checks++;
        if (if16.issue_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%0b exp=0", if16.issue_valid_o);
        end
        checks++;
        if (if16.issue_tid_o !== 4'd0) begin
            failures++;
            $display("FAIL rst_tid got=%0d exp=0", if16.issue_tid_o);
        end
        checks++;
        if (if16.running_o !== 16'h0000) begin
            failures++;
            $display("FAIL rst_running got=%0h exp=0", if16.running_o);
        end
        checks++;
        if (if16.drained_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_drained got=%0b exp=1", if16.drained_o);
        end
        checks++;
        if (if6.issue_pc_o !== 12'h040) begin
            failures++;
            $display("FAIL rst_pc6 got=%0h exp=40", if6.issue_pc_o);
        end
        reset_n = 1;
        tick();
    endtask

    task automatic test_single_thread();
        int nvalid = 0;
        if16.start_i = 1; if16.start_mask_i = 16'h0001;
        tick();
        if16.start_i = 0; if16.start_mask_i = '0;
        checks++;
        if (if16.running_o !== 16'h0001 || if16.drained_o !== 1'b0) begin
            failures++;
            $display("FAIL start_one got=%0h/%0b exp=1/0",
                     if16.running_o, if16.drained_o);
        end
        for (int i = 0; i < 48; i++) begin
            tick();
            if (if16.issue_valid_o) begin
                nvalid++;
                checks++;
                if (if16.issue_tid_o !== 4'd0 || if16.issue_pc_o !== 12'h000) begin
                    failures++;
                    $display("FAIL one_issue got=%0d/%0h exp=0/0",
                             if16.issue_tid_o, if16.issue_pc_o);
                end
            end
        end
        checks++;
        if (nvalid != 3) begin
            failures++;
            $display("FAIL one_rate got=%0d exp=3", nvalid);
        end
    endtask

    task automatic test_writeback();
        int n = 0;
        while (!(if16.issue_valid_o && if16.issue_tid_o == 4'd0) && n < 32) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 32) begin
            failures++;
            $display("FAIL wb_sync got=timeout exp=tid0");
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!if16.issue_valid_o || if16.issue_tid_o !== 4'd0 ||
                if16.issue_pc_o !== 12'(k)) begin
                failures++;
                $display("FAIL wb_seq got=%0b/%0d/%0h exp=1/0/%0h",
                         if16.issue_valid_o, if16.issue_tid_o,
                         if16.issue_pc_o, k);
            end
            if (k < 4) begin
                repeat (15) tick();
                if16.wb_valid_i = 1; if16.wb_tid_i = 4'd0;
                if16.wb_pc_i = 12'(k + 1);
                tick();
                if16.wb_valid_i = 0;
            end
        end
        // Writeback to a halted thread must not land.
        if16.wb_valid_i = 1; if16.wb_tid_i = 4'd5; if16.wb_pc_i = 12'h077;
        tick();
        if16.wb_valid_i = 0;
        n = 0;
        while (if16.issue_tid_o != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (if16.issue_valid_o !== 1'b0 || if16.issue_pc_o !== 12'h000) begin
            failures++;
            $display("FAIL wb_ignored got=%0b/%0h exp=0/0",
                     if16.issue_valid_o, if16.issue_pc_o);
        end
        if16.start_i = 1; if16.start_mask_i = 16'h0001;
        tick();
        if16.start_i = 0; if16.start_mask_i = '0;
        n = 0;
        while (if16.issue_tid_o != 4'd0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (if16.issue_pc_o !== 12'h004) begin
            failures++;
            $display("FAIL no_reload got=%0h exp=4", if16.issue_pc_o);
        end
        if16.halt_i = 1; if16.halt_mask_i = 16'h0001;
        tick();
        if16.halt_i = 0; if16.halt_mask_i = '0;
        repeat (20) tick();
        checks++;
        if (if16.drained_o !== 1'b1) begin
            failures++;
            $display("FAIL wb_drain got=%0b exp=1", if16.drained_o);
        end
    endtask

    task automatic test_nonpow2();
        int n = 0;
        int exp_tid;
        if6.start_i = 1; if6.start_mask_i = 6'h3F;
        tick();
        if6.start_i = 0; if6.start_mask_i = '0;
        while (!if6.issue_valid_o && n < 10) begin
            tick();
            n++;
        end
        exp_tid = int'(if6.issue_tid_o);
        for (int i = 0; i < 13; i++) begin
            tick();
            exp_tid = (exp_tid == 5) ? 0 : exp_tid + 1;
            checks++;
            if (!if6.issue_valid_o || if6.issue_tid_o !== 3'(exp_tid) ||
                if6.issue_pc_o !== 12'h040) begin
                failures++;
                $display("FAIL np2_seq got=%0b/%0d/%0h exp=1/%0d/40",
                         if6.issue_valid_o, if6.issue_tid_o,
                         if6.issue_pc_o, exp_tid);
            end
        end
        if6.halt_i = 1; if6.halt_mask_i = 6'h3F;
        tick();
        if6.halt_i = 0; if6.halt_mask_i = '0;
        repeat (10) tick();
        checks++;
        if (if6.drained_o !== 1'b1 || if6.running_o !== 6'h00) begin
            failures++;
            $display("FAIL np2_drain got=%0b/%0h exp=1/0",
                     if6.drained_o, if6.running_o);
        end
    endtask

    task automatic test_start_halt_same();
        int nvalid = 0;
        int ndrop = 0;
        if16.start_i = 1; if16.start_mask_i = 16'h0003;
        if16.halt_i = 1;  if16.halt_mask_i = 16'h0003;
        tick();
        if16.start_i = 0; if16.halt_i = 0;
        if16.start_mask_i = '0; if16.halt_mask_i = '0;
        checks++;
        if (if16.running_o !== 16'h0000 || if16.drained_o !== 1'b1) begin
            failures++;
            $display("FAIL sh_same got=%0h/%0b exp=0/1",
                     if16.running_o, if16.drained_o);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            if (if16.issue_valid_o) nvalid++;
            if (!if16.drained_o) ndrop++;
        end
        checks++;
        if (nvalid != 0 || ndrop != 0) begin
            failures++;
            $display("FAIL sh_idle got=%0d/%0d exp=0/0", nvalid, ndrop);
        end
    endtask

    task automatic test_drain();
        int n = 0;
        int rises = 0;
        if16.start_i = 1; if16.start_mask_i = 16'h00FF;
        tick();
        if16.start_i = 0; if16.start_mask_i = '0;
        repeat (20) tick();
        if16.halt_i = 1; if16.halt_mask_i = 16'h00FF;
        tick();
        if16.halt_i = 0; if16.halt_mask_i = '0;
        checks++;
        if (if16.running_o !== 16'h0000 || if16.drained_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_enter got=%0h/%0b exp=0/0",
                     if16.running_o, if16.drained_o);
        end
        while (!if16.drained_o && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL drain_len got=%0d exp=16", n);
        end
        if16.start_i = 1; if16.start_mask_i = 16'h00FF;
        tick();
        if16.start_i = 0; if16.start_mask_i = '0;
        repeat (10) tick();
        if16.halt_i = 1; if16.halt_mask_i = 16'h00FF;
        tick();
        if16.halt_i = 0; if16.halt_mask_i = '0;
        repeat (4) tick();
        if16.start_i = 1; if16.start_mask_i = 16'h0001;
        tick();
        if16.start_i = 0; if16.start_mask_i = '0;
        checks++;
        if (if16.running_o !== 16'h0001) begin
            failures++;
            $display("FAIL drain_restart got=%0h exp=1", if16.running_o);
        end
        for (int i = 0; i < 30; i++) begin
            if (if16.drained_o) rises++;
            tick();
        end
        checks++;
        if (rises != 0) begin
            failures++;
            $display("FAIL drain_hold got=%0d exp=0", rises);
        end
        if16.halt_i = 1; if16.halt_mask_i = 16'h0001;
        tick();
        if16.halt_i = 0; if16.halt_mask_i = '0;
        repeat (20) tick();
        checks++;
        if (if16.drained_o !== 1'b1) begin
            failures++;
            $display("FAIL drain_final got=%0b exp=1", if16.drained_o);
        end
    endtask

`ifdef BARREL_SCHED_PERF_EN
    task automatic test_perf();
        if16.cnt_sel_i = 4'd3;
        if16.start_i = 1; if16.start_mask_i = 16'h0008;
        tick();
        if16.start_i = 0; if16.start_mask_i = '0;
        repeat (159) tick();
        if16.halt_i = 1; if16.halt_mask_i = 16'h0008;
        tick();
        if16.halt_i = 0; if16.halt_mask_i = '0;
        repeat (4) tick();
        checks++;
        if (if16.cnt_value_o !== 32'd10) begin
            failures++;
            $display("FAIL perf_cnt got=%0d exp=10", if16.cnt_value_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_thread();
        test_writeback();
        test_nonpow2();
        test_start_halt_same();
        test_drain();
`ifdef BARREL_SCHED_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
